branch_predictor: RTL and testbench

// Branch predictor that supplies the predict bit to PCSel in F and consumes the
// 3-bit {is_branch, predict, correct} result from the X-stage branch checker.

---
 rtl/branch_predictor.sv | 127 ++++++++++++
 tb/tb_branch_predictor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter branch predictor.
// F-stage lookup is combinational; the lookup index travels down an internal
// F->X pipe so the resolving branch trains the entry that produced its guess.
// Also tracks resolved-branch and mispredict counts.

// One table entry: a 2-bit saturating counter with async reset.
module bp_ctr #(
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       taken,
  output logic [1:0] cnt
);

  // Saturating step toward taken (11) or not-taken (00) on an update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_INIT;
    end else if (en) begin
      if (taken) begin
        if (cnt != 2'b11) cnt <= cnt + 2'b01;
      end else begin
        if (cnt != 2'b00) cnt <= cnt - 2'b01;
      end
    end
  end

endmodule

module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter int         PIPE_DEPTH = 2,
  parameter logic [1:0] CNT_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  result,
  output logic        predict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int NUM_ENT = 1 << INDEX_BITS;

  logic [INDEX_BITS-1:0]                 idx_f;
  logic [NUM_ENT-1:0][1:0]               cnt_tbl;
  logic [PIPE_DEPTH-1:0]                 vld_pipe;
  logic [PIPE_DEPTH-1:0][INDEX_BITS-1:0] idx_pipe;
  logic [INDEX_BITS-1:0]                 tail_idx;
  logic                                  is_branch;
  logic                                  taken;
  logic                                  upd;
  logic [1:0]                            tail_cnt;
  logic [1:0]                            fwd_cnt;

  // Word-aligned PC: the low two bits and the bits above the index never matter.
  logic unused_pc;
  assign unused_pc = ^{pc_f[31:INDEX_BITS+2], pc_f[1:0]};

  assign idx_f     = pc_f[INDEX_BITS+1:2];
  assign tail_idx  = idx_pipe[PIPE_DEPTH-1];
  assign is_branch = result[2];
  // A correct not-taken guess or a wrong taken guess both mean not taken.
  assign taken     = ~(result[1] ^ result[0]);
  // Fires once per branch: only on the cycle the X-stage entry actually leaves.
  assign upd       = is_branch & ~stall & vld_pipe[PIPE_DEPTH-1];

  // Counter table, one saturating counter per entry.
  for (genvar e = 0; e < NUM_ENT; e++) begin : g_ent
    bp_ctr #(.CNT_INIT(CNT_INIT)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (upd && (tail_idx == INDEX_BITS'(e))),
      .taken (taken),
      .cnt   (cnt_tbl[e])
    );
  end

  // Post-update value of the tail entry, used to forward into this cycle's lookup.
  always_comb begin
    tail_cnt = cnt_tbl[tail_idx];
    fwd_cnt  = tail_cnt;
    if (taken) begin
      if (tail_cnt != 2'b11) fwd_cnt = tail_cnt + 2'b01;
    end else begin
      if (tail_cnt != 2'b00) fwd_cnt = tail_cnt - 2'b01;
    end
  end

  // Lookup; a same-cycle update of the same entry is visible immediately.
  always_comb begin
    predict = cnt_tbl[idx_f][1];
    if (upd && (idx_f == tail_idx)) predict = fwd_cnt[1];
  end

  // Index pipe: shifts when not stalled; flush kills everything including the new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else if (!stall) begin
      vld_pipe[0] <= ~flush;
      idx_pipe[0] <= idx_f;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1] & ~flush;
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  // Performance counters, wrapping at 2**32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd) begin
      branch_count <= branch_count + 32'd1;
      if (!result[0]) mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: the stimulus process computes the
// expected outputs from a plain array/pipe reference model and queues them;
// a monitor on the falling edge pops and compares.
module tb_branch_predictor;

  localparam int IB = 6;
  localparam int PD = 2;
  localparam int NE = 1 << IB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_f = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  result = '0;
  logic        predict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor #(.INDEX_BITS(IB), .PIPE_DEPTH(PD), .CNT_INIT(2'b01)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_f             (pc_f),
    .stall            (stall),
    .flush            (flush),
    .result           (result),
    .predict          (predict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic [31:0] bc;
    logic [31:0] mc;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   done   = 0;

  // Reference model state
  int          m_tbl [NE];
  bit          m_v   [PD];
  int          m_i   [PD];
  logic [31:0] m_bc, m_mc;

  function automatic void model_reset();
    for (int k = 0; k < NE; k++) m_tbl[k] = 1;
    for (int k = 0; k < PD; k++) begin m_v[k] = 0; m_i[k] = 0; end
    m_bc = 0;
    m_mc = 0;
  endfunction

  // One cycle: drive inputs just after the rising edge, queue the expectation,
  // then advance the model to what the next edge produces.
  task automatic step(input logic [31:0] pc, input bit st, input bit fl,
                      input logic [2:0] res, input bit rs);
    exp_t e;
    int   idx, newv;
    bit   fire, tk;
    @(posedge clk); #1;
    pc_f = pc; stall = st; flush = fl; result = res; rst = rs;
    cyc++;
    e.cyc = cyc;
    idx = int'(pc[IB+1:2]);
    if (rs) begin
      model_reset();
      e.p = 1'b0; e.bc = 0; e.mc = 0;
      exp_q.push_back(e);
      return;
    end
    tk   = (res[1] == res[0]);
    fire = res[2] && !st && m_v[PD-1];
    newv = m_tbl[m_i[PD-1]];
    if (fire) newv = tk ? ((newv < 3) ? newv + 1 : 3) : ((newv > 0) ? newv - 1 : 0);
    e.p  = (fire && idx == m_i[PD-1]) ? (newv >= 2) : (m_tbl[idx] >= 2);
    e.bc = m_bc;
    e.mc = m_mc;
    exp_q.push_back(e);
    if (fire) begin
      m_tbl[m_i[PD-1]] = newv;
      m_bc++;
      if (!res[0]) m_mc++;
    end
    if (!st) begin
      for (int k = PD - 1; k > 0; k--) begin m_v[k] = m_v[k-1]; m_i[k] = m_i[k-1]; end
      m_v[0] = 1; m_i[0] = idx;
      if (fl) for (int k = 0; k < PD; k++) m_v[k] = 0;
    end
  endtask

  // Monitor: compare outputs mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (predict !== e.p) begin
          errors++;
          $display("FAIL predict cyc=%0d got=%b exp=%b", e.cyc, predict, e.p);
        end
        if (branch_count !== e.bc) begin
          errors++;
          $display("FAIL branch_count cyc=%0d got=%0d exp=%0d", e.cyc, branch_count, e.bc);
        end
        if (mispredict_count !== e.mc) begin
          errors++;
          $display("FAIL mispredict_count cyc=%0d got=%0d exp=%0d", e.cyc, mispredict_count, e.mc);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
    end
  end

  initial begin
    model_reset();
    // Reset state
    step(32'h0, 0, 0, 3'b000, 1);
    step(32'h0, 0, 0, 3'b000, 1);
    // Sweep all word addresses: untrained table predicts not taken
    for (int a = 0; a < NE; a++) step(32'(a * 4), 0, 0, 3'b000, 0);
    // Train entry 0x10 twice taken (one mispredict, one correct)
    step(32'h40, 0, 0, 3'b000, 0);
    step(32'h40, 0, 0, 3'b000, 0);
    step(32'h40, 0, 0, 3'b100, 0);
    step(32'h40, 0, 0, 3'b111, 0);
    step(32'h40, 0, 0, 3'b000, 0);
    // Four not-taken through an aliasing PC; saturates at 00
    for (int k = 0; k < 4; k++) step(32'h140, 0, 0, 3'b110, 0);
    step(32'h40, 0, 0, 3'b000, 0);
    step(32'h140, 0, 0, 3'b000, 0);
    // Stall holding a branch in X for 3 cycles: one update when released
    step(32'h80, 0, 0, 3'b000, 0);
    step(32'h80, 0, 0, 3'b000, 0);
    for (int k = 0; k < 3; k++) step(32'h80, 1, 0, 3'b111, 0);
    step(32'h80, 0, 0, 3'b111, 0);
    step(32'h80, 0, 0, 3'b000, 0);
    // Flush with a valid X branch: it updates, the following PD cycles do not
    step(32'hC0, 0, 0, 3'b000, 0);
    step(32'hC0, 0, 0, 3'b000, 0);
    step(32'hC0, 0, 1, 3'b100, 0);
    for (int k = 0; k < PD; k++) step(32'hC0, 0, 0, 3'b100, 0);
    step(32'hC0, 0, 0, 3'b000, 0);
    // Flush while stalled is ignored
    step(32'hC4, 0, 0, 3'b000, 0);
    step(32'hC4, 0, 0, 3'b000, 0);
    step(32'hC4, 1, 1, 3'b100, 0);
    step(32'hC4, 0, 0, 3'b100, 0);
    // Same-cycle forwarding from a fresh 01 entry
    step(32'h0, 0, 0, 3'b000, 1);
    step(32'h14, 0, 0, 3'b000, 0);
    step(32'h14, 0, 0, 3'b000, 0);
    step(32'h14, 0, 0, 3'b100, 0);
    // Mid-stream reset clears before the next edge
    step(32'h14, 0, 0, 3'b111, 0);
    step(32'h14, 0, 0, 3'b111, 1);
    step(32'h14, 0, 0, 3'b000, 0);
    // Random traffic over a small index set to provoke hazards and aliasing
    for (int n = 0; n < 2500; n++) begin
      logic [31:0] pc;
      pc = {$urandom_range(0, 3), 4'b0, 2'($urandom_range(0, 3)), 2'b00} | (32'($urandom_range(0, 1)) << 8);
      step(pc, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
           3'($urandom), ($urandom_range(0, 199) == 0));
    end
    step(32'h0, 0, 0, 3'b000, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
